// File: rtl/sha_double_hash_result_checker.sv
// -----------------------------------------------------------------------------
// sha_double_hash_result_checker
//
// Consumer of one pipelined double-SHA core. It tracks which nonce each
// doublehash belongs to, compares each hash against the difficulty target, and
// buffers winning nonces in a small FIFO. The miner controller drains that FIFO
// over a valid/ready handshake.
//
// Optional feature macro: SHA_RESULT_HASH_OUT_EN
//   defined   -> each FIFO entry also holds the 256-bit hash value V, and the
//                result_hash port carries the head entry's V
//   undefined -> result_hash is absent and the FIFO holds nonces only
//
// Ports
//   clk           clock
//   rst           asynchronous, active-low reset
//   newblock_i    job-start strobe, the same one fed into the core's input
//   doublehash_i  core output a..h; doublehash_i[7] = a ... doublehash_i[0] = h
//   target_i      difficulty target, stable for the whole job
//   result_valid  FIFO non-empty
//   result_ready  consumer accepts the head entry
//   result_nonce  nonce of the head entry (0 while the FIFO is empty)
//   result_hash   V of the head entry (macro builds only, 0 while empty)
//   search_done   1-cycle pulse after the last nonce of the job was checked
//   overflow      sticky: a hit was dropped because the FIFO was full
//   hits_count    saturating count of hits in this job
// -----------------------------------------------------------------------------
module sha_double_hash_result_checker #(
  parameter int unsigned PROCESSORINDEX = 0,
  parameter int unsigned NUMPROCESSORS  = 1,
  parameter int unsigned LATENCY        = 130,
  parameter int unsigned NONCE_BITS     = 32,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  newblock_i,
  input  logic [7:0][31:0]      doublehash_i,
  input  logic [255:0]          target_i,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [NONCE_BITS-1:0] result_nonce,
`ifdef SHA_RESULT_HASH_OUT_EN
  output logic [255:0]          result_hash,
`endif
  output logic                  search_done,
  output logic                  overflow,
  output logic [15:0]           hits_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [63:0] MAX_NONCE = (64'd1 << NONCE_BITS) - 64'd1;
  localparam logic [NONCE_BITS-1:0] FIRST_NONCE = NONCE_BITS'(PROCESSORINDEX);
`ifdef SHA_RESULT_HASH_OUT_EN
  localparam int unsigned ENTRY_W = NONCE_BITS + 256;
`else
  localparam int unsigned ENTRY_W = NONCE_BITS;
`endif

  typedef enum logic {ST_IDLE, ST_ARMED} state_e;

  // ---------------------------------------------------------------------------
  // newblock delay line: nb_d marks the cycle whose hash belongs to the first
  // nonce of a job.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] nb_sr_q;
  logic               nb_d;

  generate
    if (LATENCY == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) nb_sr_q <= '0;
        else      nb_sr_q <= newblock_i;
      end
    end else begin : g_lat_many
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) nb_sr_q <= '0;
        else      nb_sr_q <= {nb_sr_q[LATENCY-2:0], newblock_i};
      end
    end
  endgenerate

  assign nb_d = nb_sr_q[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Hash value in Bitcoin order: byte-reverse of {a,b,...,h}.
  // ---------------------------------------------------------------------------
  logic [255:0] hash_v;

  always_comb begin
    hash_v = '0;
    for (int i = 0; i < 32; i++) hash_v[8*i +: 8] = doublehash_i[(31-i)/4][8*((31-i)%4) +: 8];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q,     state_d;
  logic [NONCE_BITS-1:0]   nonce_q,     nonce_d;
  logic                    done_q,      done_d;
  logic                    hit_q,       hit_d;
  logic [ENTRY_W-1:0]      hit_entry_q, hit_entry_d;
  logic [PTR_W:0]          wr_ptr_q,    wr_ptr_d;
  logic [PTR_W:0]          rd_ptr_q,    rd_ptr_d;
  logic [15:0]             hits_q,      hits_d;
  logic                    ovf_q,       ovf_d;
  logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];

  logic                  check_en;
  logic [NONCE_BITS-1:0] cur_nonce;
  logic [63:0]           nonce_sum;
  logic                  last_nonce;
  logic                  fifo_empty, fifo_full, push, pop;

  // A restart (nb_d) takes priority over whatever the armed job was doing.
  assign check_en   = nb_d || (state_q == ST_ARMED);
  assign cur_nonce  = nb_d ? FIRST_NONCE : nonce_q;
  assign nonce_sum  = 64'(cur_nonce) + 64'(NUMPROCESSORS);
  assign last_nonce = (nonce_sum > MAX_NONCE);

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && result_ready;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign push       = hit_q && (!fifo_full || pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d     = state_q;
    nonce_d     = nonce_q;
    done_d      = 1'b0;
    hit_d       = check_en && (hash_v < target_i);
`ifdef SHA_RESULT_HASH_OUT_EN
    hit_entry_d = {cur_nonce, hash_v};
`else
    hit_entry_d = cur_nonce;
`endif
    wr_ptr_d    = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    hits_d      = hits_q;
    ovf_d       = ovf_q;

    if (check_en) begin
      nonce_d = nonce_sum[NONCE_BITS-1:0];
      if (last_nonce) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_ARMED;
      end
    end

    // A job start clears the per-job statistics; a late hit from the
    // abandoned job is still queued but not counted.
    if (nb_d) begin
      hits_d = '0;
      ovf_d  = 1'b0;
    end else if (hit_q) begin
      if (hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
      if (!push)              ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      nonce_q     <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_entry_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hits_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      hit_entry_q <= hit_entry_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hits_q      <= hits_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: the storage array has no reset; the head is gated by result_valid
  // instead, so stale contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= hit_entry_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] head;

  assign result_valid = !fifo_empty;
  assign head         = fifo_empty ? '0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign result_nonce = head[ENTRY_W-1 -: NONCE_BITS];
`ifdef SHA_RESULT_HASH_OUT_EN
  assign result_hash  = head[255:0];
`endif
  assign search_done  = done_q;
  assign overflow     = ovf_q;
  assign hits_count   = hits_q;

endmodule
